// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: button arbitration, fast spin, tick-paced settle, and timed result display.
// Optional macro ROLL_COUNT_EN adds a saturating completed-roll counter on roll_count.
module dice_roll_ctrl #(
  parameter int SETTLE_STEPS = 8,
  parameter int SHOW_TICKS   = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [6:0] btn,
  output logic [3:0] digit10,
  output logic [3:0] digit1,
  output logic       display_en,
  output logic [2:0] die_sel,
  output logic       result_valid,
  output logic       busy,
  output logic [7:0] roll_count
);

  typedef enum logic [1:0] {IDLE, ROLLING, SETTLE, SHOW} state_t;

  state_t     state_reg, state_next;
  logic       any_q;
  logic [7:0] value_reg, value_next;
  logic [2:0] sel_reg, sel_next;
  logic [7:0] settle_cnt_reg, settle_cnt_next;
  logic [7:0] show_cnt_reg, show_cnt_next;
  logic       valid_reg, valid_next;
  logic [2:0] grant;
  logic       new_press;
  logic [7:0] btn_ext;

  // Die size as two BCD digits; d100 is encoded as 00.
  function automatic logic [7:0] sides_bcd(input logic [2:0] sel);
    case (sel)
      3'd0:    return 8'h04;
      3'd1:    return 8'h06;
      3'd2:    return 8'h08;
      3'd3:    return 8'h10;
      3'd4:    return 8'h12;
      3'd5:    return 8'h20;
      3'd6:    return 8'h00;
      default: return 8'h04;
    endcase
  endfunction

  function automatic logic [7:0] step_bcd(input logic [7:0] v, input logic [7:0] top);
    if (v == 8'h01)
      return top;
    if (v[3:0] == 4'd0)
      return {(v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign new_press = (|btn) && !any_q;
  assign btn_ext   = {1'b0, btn};

  always_comb begin
    grant = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (btn[i]) grant = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    // any_q follows the buttons through reset so a held button never looks new.
    any_q <= |btn;
    if (!rst_n) begin
      state_reg      <= IDLE;
      value_reg      <= 8'h01;
      sel_reg        <= 3'd0;
      settle_cnt_reg <= 8'd0;
      show_cnt_reg   <= 8'd0;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      value_reg      <= value_next;
      sel_reg        <= sel_next;
      settle_cnt_reg <= settle_cnt_next;
      show_cnt_reg   <= show_cnt_next;
      valid_reg      <= valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    value_next      = value_reg;
    sel_next        = sel_reg;
    settle_cnt_next = settle_cnt_reg;
    show_cnt_next   = show_cnt_reg;
    valid_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (new_press) begin
          state_next = ROLLING;
          sel_next   = grant;
          value_next = sides_bcd(grant);
        end
      end
      ROLLING: begin
        // Release takes the transition only; no step on that edge.
        if (!btn_ext[sel_reg]) begin
          state_next      = SETTLE;
          settle_cnt_next = 8'(SETTLE_STEPS);
        end else begin
          value_next = step_bcd(value_reg, sides_bcd(sel_reg));
        end
      end
      SETTLE: begin
        if (tick) begin
          value_next      = step_bcd(value_reg, sides_bcd(sel_reg));
          settle_cnt_next = settle_cnt_reg - 8'd1;
          if (settle_cnt_reg == 8'd1) begin
            state_next    = SHOW;
            valid_next    = 1'b1;
            show_cnt_next = 8'(SHOW_TICKS);
          end
        end
      end
      SHOW: begin
        // A new press beats the final display tick.
        if (new_press) begin
          state_next = ROLLING;
          sel_next   = grant;
          value_next = sides_bcd(grant);
        end else if (tick) begin
          show_cnt_next = show_cnt_reg - 8'd1;
          if (show_cnt_reg == 8'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign digit10      = value_reg[7:4];
  assign digit1       = value_reg[3:0];
  assign die_sel      = sel_reg;
  assign result_valid = valid_reg;
  assign display_en   = (state_reg == SETTLE) || (state_reg == SHOW);
  assign busy         = (state_reg == ROLLING) || (state_reg == SETTLE);

`ifdef ROLL_COUNT_EN
  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count_reg <= 8'd0;
    else if (valid_next && count_reg != 8'hFF)
      count_reg <= count_reg + 8'd1;
  end

  assign roll_count = count_reg;
`else
  assign roll_count = 8'd0;
`endif

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed table-driven bench for dice_roll_ctrl; define ROLL_COUNT_EN to match an RTL build with the counter.
module tb_dice_roll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [6:0] btn;
  logic [3:0] digit10;
  logic [3:0] digit1;
  logic       display_en;
  logic [2:0] die_sel;
  logic       result_valid;
  logic       busy;
  logic [7:0] roll_count;

  always #5 clk = ~clk;

  dice_roll_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .btn          (btn),
    .digit10      (digit10),
    .digit1       (digit1),
    .display_en   (display_en),
    .die_sel      (die_sel),
    .result_valid (result_valid),
    .busy         (busy),
    .roll_count   (roll_count)
  );

  typedef struct {
    logic       rst_n;
    logic       tick;
    logic [6:0] btn;
    logic [3:0] t;
    logic [3:0] u;
    logic       den;
    logic       bsy;
    logic       rv;
    logic [2:0] sel;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_rolls = 0;
  vec_t tab[$];

  function automatic vec_t mk(input logic r, input logic tk, input logic [6:0] b,
                              input int val, input logic den, input logic bsy,
                              input logic rv, input logic [2:0] sel);
    vec_t v;
    v.rst_n = r;
    v.tick  = tk;
    v.btn   = b;
    v.t     = 4'((val % 100) / 10);
    v.u     = 4'(val % 10);
    v.den   = den;
    v.bsy   = bsy;
    v.rv    = rv;
    v.sel   = sel;
    return v;
  endfunction

  // Drive one cycle of inputs, then compare every output #1 after the edge.
  task automatic apply(input vec_t v, input string name, input int idx);
    logic [7:0] exp_rc;
    rst_n = v.rst_n;
    tick  = v.tick;
    btn   = v.btn;
    @(posedge clk);
    #1;
    if (!v.rst_n) exp_rolls = 0;
    else if (v.rv && exp_rolls < 255) exp_rolls++;
`ifdef ROLL_COUNT_EN
    exp_rc = 8'(exp_rolls);
`else
    exp_rc = 8'd0;
`endif
    n_checks++;
    if ({digit10, digit1, display_en, busy, result_valid, die_sel, roll_count} !==
        {v.t, v.u, v.den, v.bsy, v.rv, v.sel, exp_rc}) begin
      n_fail++;
      $display("FAIL %s[%0d]: got d=%h%h en=%b busy=%b rv=%b sel=%0d cnt=%0d, expected d=%h%h en=%b busy=%b rv=%b sel=%0d cnt=%0d",
               name, idx, digit10, digit1, display_en, busy, result_valid, die_sel, roll_count,
               v.t, v.u, v.den, v.bsy, v.rv, v.sel, exp_rc);
    end
  endtask

  task automatic run_table(input string name);
    foreach (tab[i]) apply(tab[i], name, i);
    tab.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    btn   = 7'd0;

    // Reset, then d10 held 7 cycles; release coincides with a tick; press during SETTLE ignored.
    tab.push_back(mk(0, 0, 7'h00, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 7'h00, 1, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++) tab.push_back(mk(1, 1'(k % 2), 7'h08, 10 - k, 0, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 4, 1, 1, 0, 3));
    tab.push_back(mk(1, 0, 7'h00, 4, 1, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 3, 1, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 2, 1, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 1, 1, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 10, 1, 1, 0, 3));
    tab.push_back(mk(1, 0, 7'h01, 10, 1, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 9, 1, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 8, 1, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 7, 1, 1, 0, 3));
    tab.push_back(mk(1, 1, 7'h00, 6, 1, 0, 1, 3));
    tab.push_back(mk(1, 0, 7'h00, 6, 1, 0, 0, 3));
    run_table("d10_roll");

    // SHOW lasts 96 ticks, then IDLE keeps the last digits.
    for (int k = 1; k < 96; k++) apply(mk(1, 1, 7'h00, 6, 1, 0, 0, 3), "show_hold", k);
    apply(mk(1, 1, 7'h00, 6, 0, 0, 0, 3), "show_end", 96);

    // d4 and d100 together: lowest index wins; d4 wraps 01->04; releasing btn[6] alone keeps rolling.
    tab.push_back(mk(1, 0, 7'h41, 4, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 7'h41, 3, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 7'h41, 2, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 7'h41, 1, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 7'h41, 4, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 7'h01, 3, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 7'h00, 3, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 7'h00, 2, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 7'h00, 1, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 7'h00, 4, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 7'h00, 3, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 7'h00, 2, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 7'h00, 1, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 7'h00, 4, 1, 1, 0, 0));
    tab.push_back(mk(1, 1, 7'h00, 3, 1, 0, 1, 0));
    run_table("d4_prio");

    // Press on the final SHOW tick wins and loads d100; held 2 cycles then settles 98..91.
    for (int k = 1; k < 96; k++) apply(mk(1, 1, 7'h00, 3, 1, 0, 0, 0), "show_hold2", k);
    apply(mk(1, 1, 7'h40, 100, 0, 1, 0, 6), "press_last_tick", 0);
    apply(mk(1, 0, 7'h40, 99, 0, 1, 0, 6), "d100_step", 1);
    apply(mk(1, 0, 7'h00, 99, 1, 1, 0, 6), "d100_release", 0);
    for (int k = 1; k <= 8; k++)
      apply(mk(1, 1, 7'h00, 99 - k, 1, ~1'(k == 8), 1'(k == 8), 6), "d100_settle", k);

    // d100 full cycle from SHOW: 00,99,...,01,00.
    apply(mk(1, 0, 7'h40, 100, 0, 1, 0, 6), "d100_load", 0);
    for (int k = 1; k <= 100; k++)
      apply(mk(1, 1'(k % 3 == 0), 7'h40, 100 - k, 0, 1, 0, 6), "d100_wrap", k);

    // Reset mid-ROLLING, then a d6 roll interrupted by reset again.
    tab.push_back(mk(0, 0, 7'h00, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 7'h00, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 7'h02, 6, 0, 1, 0, 1));
    tab.push_back(mk(1, 1, 7'h02, 5, 0, 1, 0, 1));
    tab.push_back(mk(0, 0, 7'h00, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 7'h00, 1, 0, 0, 0, 0));
    run_table("reset_mid_roll");

    // 256 back-to-back d4 rolls; the counter (when built) saturates at 255.
    for (int r = 0; r < 256; r++) begin
      apply(mk(1, 0, 7'h01, 4, 0, 1, 0, 0), "rc_press", r);
      apply(mk(1, 0, 7'h00, 4, 1, 1, 0, 0), "rc_release", r);
      for (int k = 1; k <= 8; k++)
        apply(mk(1, 1, 7'h00, ((4 - k) % 4 + 4) % 4 == 0 ? 4 : ((4 - k) % 4 + 4) % 4,
                 1, ~1'(k == 8), 1'(k == 8), 0), "rc_settle", r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
